// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the multi-cycle 32-bit divider.
//   - FSM state encoding (two bits, matching the pipeline's legacy defines)
//   - result-ready / start-stop levels and the DIV/DIVU aluop codes
//   - cond_neg(): two's-complement negate when a flag is set, used both to
//     take operand magnitudes and to restore result signs
package div_pkg;

  localparam int unsigned REG_W  = 32;
  localparam int unsigned DREG_W = 64;

  // One quotient bit is produced per iteration.
  localparam logic [5:0] DIV_ITERS = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  function automatic logic [REG_W-1:0] cond_neg(input logic [REG_W-1:0] value,
                                                input logic             neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_if.sv
// div_if -- request/response bundle between the execute stage and the divider.
//   signed_div_i : 1 = DIV (signed), 0 = DIVU
//   opdata1_i    : dividend
//   opdata2_i    : divisor
//   start_i      : request, held by the requester until ready_o is seen
//   annul_i      : cancel an in-flight division (pipeline flush)
//   result_o     : {remainder, quotient}
//   ready_o      : result valid
// Modports: master = execute stage, slave = divider.
interface div_if;
  import div_pkg::*;

  logic              signed_div_i;
  logic [REG_W-1:0]  opdata1_i;
  logic [REG_W-1:0]  opdata2_i;
  logic              start_i;
  logic              annul_i;
  logic [DREG_W-1:0] result_o;
  logic              ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div.sv
// div -- multi-cycle 32-bit divider for DIV/DIVU.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock; signs are reapplied at the end. Result is {remainder, quotient}.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : div_if.slave (request operands in, result/ready out)
// Latency from the accepting edge: 33 further edges for a nonzero divisor,
// one edge for a zero divisor (result is all zeros). All outputs registered.
module div
  import div_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  div_state_e        state_q, state_d;
  logic [5:0]        counter_q, counter_d;
  // {overflow bit, partial remainder, remaining dividend bits / quotient bits}
  logic [64:0]       work_q, work_d;
  logic [REG_W-1:0]  divisor_q, divisor_d;
  logic              dividend_neg_q, dividend_neg_d;
  logic              divisor_neg_q, divisor_neg_d;
  logic [DREG_W-1:0] result_q, result_d;
  logic              ready_q, ready_d;

  logic              op1_neg, op2_neg;
  logic [32:0]       partial;
  logic              take;

  assign op1_neg = bus.signed_div_i & bus.opdata1_i[REG_W-1];
  assign op2_neg = bus.signed_div_i & bus.opdata2_i[REG_W-1];

  // Trial subtraction. The shifted partial remainder can reach 33 bits
  // (its top bit lives in work_q[64]); when that bit is set the value
  // certainly exceeds the divisor, so the subtraction is taken regardless
  // of the 33-bit borrow, and the low 32 bits of partial are exact.
  assign partial = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  assign take    = work_q[64] | ~partial[32];

  // NOTE: combinational next-state logic uses blocking assignments and
  // assigns every output a default first, so no latch can be inferred;
  // the register block below uses non-blocking assignments only.
  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    work_d         = work_q;
    divisor_d      = divisor_q;
    dividend_neg_d = dividend_neg_q;
    divisor_neg_d  = divisor_neg_q;
    result_d       = result_q;
    ready_d        = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        ready_d  = DIV_RESULT_NOT_READY;
        result_d = '0;
        if (bus.start_i == DIV_START && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d        = DIV_ON;
            counter_d      = '0;
            dividend_neg_d = op1_neg;
            divisor_neg_d  = op2_neg;
            divisor_d      = cond_neg(bus.opdata2_i, op2_neg);
            work_d         = {32'b0, cond_neg(bus.opdata1_i, op1_neg), 1'b0};
          end
        end
      end

      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        ready_d  = DIV_RESULT_READY;
        result_d = '0;
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end else if (counter_q != DIV_ITERS) begin
          work_d    = take ? {partial[31:0], work_q[31:0], 1'b1}
                           : {work_q[63:0], 1'b0};
          counter_d = counter_q + 6'd1;
        end else begin
          state_d  = DIV_END;
          ready_d  = DIV_RESULT_READY;
          result_d = {cond_neg(work_q[64:33], dividend_neg_q),
                      cond_neg(work_q[31:0], dividend_neg_q ^ divisor_neg_q)};
        end
      end

      DIV_END: begin
        if (bus.start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = '0;
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  // NOTE: only control state and visible outputs are reset; the datapath
  // registers (work, divisor, sign flags) are always reloaded on acceptance
  // before they are read, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      counter_q <= '0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    work_q         <= work_d;
    divisor_q      <= divisor_d;
    dividend_neg_q <= dividend_neg_d;
    divisor_neg_q  <= divisor_neg_d;
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// tb_div -- directed testbench for the multi-cycle divider.
// Inputs are driven on the falling edge; outputs are sampled 1ns after the
// rising edge. Expected values are hand-computed constants.
module tb_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue a request, scramble the operand inputs after the accepting edge,
  // and report how many edges after acceptance ready_o rose (-1 on timeout).
  // start_i is left high on return.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, output int lat,
                        output logic [63:0] res);
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.opdata1_i    = 32'hDEAD_BEEF;
    bus.opdata2_i    = 32'h0000_0000;
    bus.signed_div_i = ~sgn;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) begin
        lat = n;
        break;
      end
    end
    res = bus.result_o;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b want=0", bus.ready_o);
    end
    checks++;
    if (bus.result_o !== 64'h0) begin
      failures++;
      $display("FAIL reset_result got=%h want=0", bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic        vs [9];
    logic [63:0] ve [9];
    int          vl [9];
    int          lat;
    logic [63:0] res;
    va[0] = 32'd100;        vb[0] = 32'd7;          vs[0] = 0; ve[0] = 64'h00000002_0000000E; vl[0] = 33;
    va[1] = 32'hFFFFFFF9;   vb[1] = 32'd2;          vs[1] = 1; ve[1] = 64'hFFFFFFFF_FFFFFFFD; vl[1] = 33;
    va[2] = 32'd7;          vb[2] = 32'hFFFFFFFE;   vs[2] = 1; ve[2] = 64'h00000001_FFFFFFFD; vl[2] = 33;
    va[3] = 32'hFFFFFFF9;   vb[3] = 32'hFFFFFFFE;   vs[3] = 1; ve[3] = 64'hFFFFFFFF_00000003; vl[3] = 33;
    va[4] = 32'h80000000;   vb[4] = 32'hFFFFFFFF;   vs[4] = 1; ve[4] = 64'h00000000_80000000; vl[4] = 33;
    va[5] = 32'hFFFFFFF9;   vb[5] = 32'd2;          vs[5] = 0; ve[5] = 64'h00000001_7FFFFFFC; vl[5] = 33;
    va[6] = 32'hFFFFFFFF;   vb[6] = 32'hFFFFFFFE;   vs[6] = 0; ve[6] = 64'h00000001_00000001; vl[6] = 33;
    va[7] = 32'hFFFFFFFF;   vb[7] = 32'd1;          vs[7] = 0; ve[7] = 64'h00000000_FFFFFFFF; vl[7] = 33;
    va[8] = 32'd5;          vb[8] = 32'd0;          vs[8] = 0; ve[8] = 64'h00000000_00000000; vl[8] = 1;
    for (int i = 0; i < 9; i++) begin
      launch(va[i], vb[i], vs[i], lat, res);
      checks++;
      if (lat !== vl[i]) begin
        failures++;
        $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, vl[i]);
      end
      checks++;
      if (res !== ve[i]) begin
        failures++;
        $display("FAIL vec%0d_result got=%h want=%h", i, res, ve[i]);
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
        failures++;
        $display("FAIL vec%0d_release got=%b/%h want=0/0", i, bus.ready_o, bus.result_o);
      end
    end
  endtask

  task automatic test_annul();
    logic        seen = 1'b0;
    int          lat;
    logic [63:0] res;
    @(negedge clk);
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);            // E0
    repeat (9) @(posedge clk); // E9
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);            // E10
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      failures++;
      $display("FAIL annul_outputs got=%b/%h want=0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    bus.annul_i = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      seen = seen | bus.ready_o;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL annul_no_ready got=%b want=0", seen);
    end
    launch(32'd9, 32'd3, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      failures++;
      $display("FAIL annul_next got=%0d/%h want=33/%h", lat, res, 64'h00000000_00000003);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic        seen = 1'b0;
    int          lat;
    logic [63:0] res;
    @(negedge clk);
    bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7; bus.signed_div_i = 1'b0;
    bus.start_i = 1'b1;
    @(posedge clk);             // E0
    repeat (14) @(posedge clk); // E14
    @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);             // E15
    #1;
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%h want=0/0", bus.ready_o, bus.result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      seen = seen | bus.ready_o;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_ready got=%b want=0", seen);
    end
    launch(32'd100, 32'd7, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000002_0000000E) begin
      failures++;
      $display("FAIL rstmid_next got=%0d/%h want=33/%h", lat, res, 64'h00000002_0000000E);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int          lat;
    logic [63:0] res;
    logic        stable = 1'b1;
    launch(32'd100, 32'd7, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000002_0000000E) begin
      failures++;
      $display("FAIL b2b_first got=%0d/%h want=33/%h", lat, res, 64'h00000002_0000000E);
    end
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold got=%b/%h want=1/%h", bus.ready_o, bus.result_o, 64'h00000002_0000000E);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got=%b want=0", bus.ready_o);
    end
    launch(32'd9, 32'd3, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== 64'h00000000_00000003) begin
      failures++;
      $display("FAIL b2b_second got=%0d/%h want=33/%h", lat, res, 64'h00000000_00000003);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit divider for DIV/DIVU; responder to the execute stage's divide request.
- Execute stage asserts start with operands and holds its stall request until ready_o. It then routes result_o to hi_o/lo_o with whilo_o=1.
- Radix-2 restoring trial subtraction, one quotient bit per clock.
- Result packed as {remainder, quotient} = {HI, LO}.

Parameters:
- None. Width is fixed by RegBus (32) and DoubleRegBus (64) in defines.v.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high (RstEnable)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by ex until ready_o seen
- annul_i  in  1  cancel in-flight division (pipeline flush)
- result_o  out  64  {remainder[31:0], quotient[31:0]}
- ready_o  out  1  result valid

Behaviour:
- Reset (rst=1 at clk edge, any state, including mid-operation):
  - state=DIV_FREE, ready_o=0, result_o=0, counter=0.
  - Partial work discarded.
- States: DIV_FREE, DIV_BY_ZERO, DIV_ON, DIV_END. All outputs registered.
- DIV_FREE:
  - Idle: ready_o=0, result_o=0.
  - At an edge with start_i=1 and annul_i=0:
    - If opdata2_i==0, go to DIV_BY_ZERO.
    - Otherwise go to DIV_ON and latch operands. When signed_div_i=1 and the MSB is set, latch the two's-complement magnitude. Clear the 6-bit counter. Load the 65-bit working register with {32'b0, |dividend|, 1'b0}.
  - start_i with annul_i=1 is ignored.
- DIV_BY_ZERO:
  - Next edge goes to DIV_END with result_o=64'h0.
- DIV_ON:
  - If annul_i=1 at an edge, go to DIV_FREE; ready_o stays 0 and result_o=0.
  - Else, while counter!=32, do one iteration per edge:
    - Compute partial = work[63:32] - |divisor| (33-bit).
    - If partial is negative: work = work<<1.
    - Else: work = {partial[31:0], work[31:0], 1'b1}.
    - counter++.
  - When counter==32, at that edge:
    - quotient = work[31:0]; remainder = work[64:33].
    - For signed: negate the quotient if dividend sign XOR divisor sign; negate the remainder if the dividend sign is set.
    - Go to DIV_END, ready_o=1, result_o=final value.
- DIV_END:
  - Hold ready_o=1 and result_o stable while start_i=1.
  - At the first edge with start_i=0, go to DIV_FREE, ready_o=0, result_o=0.
  - annul_i is ignored in this state.
- Latency: let E0 be the accepting edge.
  - Nonzero divisor: iterations at E1..E32; ready_o=1 after E33, i.e. 34 edges from request to result.
  - Zero divisor: ready_o=1 after E1.
- Arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wrap), remainder 0. No trap.
  - Divide by zero gives all zeros.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Operand inputs may change after E0 without effect.
- A new request is accepted only from DIV_FREE.

Decomposition:
- defines.v gains:
  - state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - EXE_DIV_OP/EXE_DIVU_OP aluop codes (if absent).
- No sub-module. The 33-bit trial subtractor is inline; splitting it out adds nothing.

Test Plan:
- DIVU 100/7: start_i=1, signed=0 → ready_o rises after E33, result_o=64'h00000002_0000000E. Drop start_i → next edge ready_o=0, result_o=0.
- DIV -7/2 (0xFFFFFFF9, 0x00000002), signed=1 → result_o=64'hFFFFFFFF_FFFFFFFD. Also DIV 7/-2 → 64'h00000001_FFFFFFFD.
- Divide by zero 5/0 → ready_o=1 after E1, result_o=0. Signed 0x80000000/0xFFFFFFFF → result_o=64'h00000000_80000000.
- Annul: start 100/7, assert annul_i for one cycle at E10 → DIV_FREE next edge, ready_o never rises. A new request 9/3 then returns 64'h00000000_00000003 after 34 edges.
- Reset mid-op: rst=1 at E15 → next cycle ready_o=0, result_o=0, state FREE. A new request after reset completes normally.
- Hold/back-to-back: keep start_i=1 for 5 cycles in DIV_END → result stable, no restart. Deassert for 1 cycle, then reassert → a second division is accepted from DIV_FREE.
